// File: rtl/snake_body_engine.sv
// Snake body position engine: shifts the body and steps the head once per screenClock rise, grows on apples, freezes on collision.
// Optional SNAKE_REVERSE_GUARD_EN: when defined, a direction exactly opposite the current heading is ignored.
module snake_body_engine #(
  parameter int SegWidth  = 10,
  parameter int SegHeight = 10,
  parameter int InitSize  = 3,
  parameter int MaxSize   = 127,
  parameter int HeadInitX = 100,
  parameter int HeadInitY = 160
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          screenClock,
  input  logic [1:0]    direction,
  input  logic          appleEaten,
  input  logic          collision,
  output logic [1023:0] snakeLocX,
  output logic [1152:0] snakeLocY,
  output logic [7:0]    size,
  output logic          moveDone,
  output logic          halted
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MOVE    = 2'd1;
  localparam logic [1:0] PUBLISH = 2'd2;
  localparam logic [1:0] HALT    = 2'd3;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [7:0] SEG_W      = 8'(SegWidth);
  localparam logic [8:0] SEG_H      = 9'(SegHeight);
  localparam logic [7:0] MAX_SIZE   = 8'(MaxSize);
  localparam logic [7:0] INIT_SIZE  = 8'(InitSize);

  logic [7:0] x_arr [0:127];
  logic [8:0] y_arr [0:127];

  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic [1:0] heading_reg;
  logic [1:0] heading_next;
  logic [2:0] sync_reg;
  logic       tick;
  logic [7:0] size_reg;
  logic       grow_pending_reg;
  logic [7:0] head_x_next;
  logic [8:0] head_y_next;

  // Reset layout: head at the start point, body stacked downward below it.
  function automatic logic [7:0] init_x(input int i);
    if (i < InitSize) return 8'(HeadInitX);
    return 8'd0;
  endfunction

  function automatic logic [8:0] init_y(input int i);
    if (i < InitSize) return 9'(HeadInitY + i * SegHeight);
    return 9'd0;
  endfunction

  // screenClock is foreign to clock: two sync flops plus one history flop for edge detect.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_reg <= 3'b000;
    end else begin
      sync_reg <= {sync_reg[1:0], screenClock};
    end
  end

  assign tick = sync_reg[1] & ~sync_reg[2];

  always_comb begin
    heading_next = direction;
`ifdef SNAKE_REVERSE_GUARD_EN
    // Opposite pairs differ only in bit 0 (up/down, left/right).
    if (direction == (heading_reg ^ 2'b01)) begin
      heading_next = heading_reg;
    end
`endif
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (collision) begin
          state_next = HALT;
        end else if (tick) begin
          state_next = MOVE;
        end
      end
      MOVE:    state_next = collision ? HALT : PUBLISH;
      PUBLISH: state_next = collision ? HALT : IDLE;
      default: state_next = HALT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      heading_reg <= DIR_UP;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && tick && !collision) begin
        heading_reg <= heading_next;
      end
    end
  end

  // Head arithmetic wraps naturally at the field widths.
  always_comb begin
    head_x_next = x_arr[0];
    head_y_next = y_arr[0];
    case (heading_reg)
      DIR_UP:    head_y_next = y_arr[0] - SEG_H;
      DIR_DOWN:  head_y_next = y_arr[0] + SEG_H;
      DIR_LEFT:  head_x_next = x_arr[0] - SEG_W;
      DIR_RIGHT: head_x_next = x_arr[0] + SEG_W;
      default:   head_x_next = x_arr[0];
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 128; i++) begin
        x_arr[i] <= init_x(i);
        y_arr[i] <= init_y(i);
      end
    end else if (state_reg == MOVE) begin
      x_arr[0] <= head_x_next;
      y_arr[0] <= head_y_next;
      for (int i = 1; i < 128; i++) begin
        x_arr[i] <= x_arr[i-1];
        y_arr[i] <= y_arr[i-1];
      end
    end
  end

  // A pulse during MOVE is kept for the following move rather than the current one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      size_reg         <= INIT_SIZE;
      grow_pending_reg <= 1'b0;
    end else if (state_reg == MOVE) begin
      if (grow_pending_reg && size_reg < MAX_SIZE) begin
        size_reg <= size_reg + 8'd1;
      end
      grow_pending_reg <= appleEaten;
    end else if (state_reg != HALT && appleEaten) begin
      grow_pending_reg <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 128; gi++) begin : g_pack
      assign snakeLocX[gi*8 +: 8] = x_arr[gi];
      assign snakeLocY[gi*9 +: 9] = y_arr[gi];
    end
  endgenerate

  assign snakeLocY[1152] = 1'b0;
  assign size            = size_reg;
  assign moveDone        = (state_reg == PUBLISH);
  assign halted          = (state_reg == HALT);

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench for snake_body_engine: a reference model pushes expected buses per move, compared when moveDone fires.
module tb_snake_body_engine;

  typedef struct {
    logic [1023:0] bx;
    logic [1152:0] by;
    logic [7:0]    sz;
  } exp_t;

  logic          clock;
  logic          reset;
  logic          screenClock;
  logic [1:0]    direction;
  logic          appleEaten;
  logic          collision;
  logic [1023:0] snakeLocX;
  logic [1152:0] snakeLocY;
  logic [7:0]    size;
  logic          moveDone;
  logic          halted;

  snake_body_engine dut (
    .clock       (clock),
    .reset       (reset),
    .screenClock (screenClock),
    .direction   (direction),
    .appleEaten  (appleEaten),
    .collision   (collision),
    .snakeLocX   (snakeLocX),
    .snakeLocY   (snakeLocY),
    .size        (size),
    .moveDone    (moveDone),
    .halted      (halted)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  logic [7:0] mx [128];
  logic [8:0] my [128];
  int         msize;
  logic [1:0] mhead;
  bit         mgrow;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_buses(input string tag, input exp_t e);
    checks++;
    assert (snakeLocX === e.bx) else begin
      errors++;
      $error("FAIL %s_busx observed_low=%h expected_low=%h", tag, snakeLocX[63:0], e.bx[63:0]);
    end
    checks++;
    assert (snakeLocY === e.by) else begin
      errors++;
      $error("FAIL %s_busy observed_low=%h expected_low=%h", tag, snakeLocY[62:0], e.by[62:0]);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 128; i++) begin
      mx[i] = (i < 3) ? 8'd100 : 8'd0;
      my[i] = (i < 3) ? 9'(160 + 10 * i) : 9'd0;
    end
    msize = 3;
    mhead = 2'b00;
    mgrow = 0;
  endfunction

  function automatic void model_move(input logic [1:0] dir);
    bit reverse;
    reverse = ((mhead == 2'b00 && dir == 2'b01) || (mhead == 2'b01 && dir == 2'b00) ||
               (mhead == 2'b10 && dir == 2'b11) || (mhead == 2'b11 && dir == 2'b10));
`ifdef SNAKE_REVERSE_GUARD_EN
    if (!reverse) mhead = dir;
`else
    if (reverse || !reverse) mhead = dir;
`endif
    for (int i = 127; i >= 1; i--) begin
      mx[i] = mx[i-1];
      my[i] = my[i-1];
    end
    case (mhead)
      2'b00:   my[0] = 9'((int'(my[0]) - 10 + 512) % 512);
      2'b01:   my[0] = 9'((int'(my[0]) + 10) % 512);
      2'b10:   mx[0] = 8'((int'(mx[0]) - 10 + 256) % 256);
      default: mx[0] = 8'((int'(mx[0]) + 10) % 256);
    endcase
    if (mgrow) begin
      if (msize < 127) msize++;
      mgrow = 0;
    end
  endfunction

  function automatic exp_t pack_model();
    exp_t e;
    for (int i = 0; i < 128; i++) begin
      e.bx[i*8 +: 8] = mx[i];
      e.by[i*9 +: 9] = my[i];
    end
    e.by[1152] = 1'b0;
    e.sz = 8'(msize);
    return e;
  endfunction

  task automatic apple();
    @(negedge clock);
    appleEaten = 1'b1;
    @(negedge clock);
    appleEaten = 1'b0;
    mgrow = 1;
  endtask

  task automatic do_move(input logic [1:0] dir);
    int   budget;
    bit   seen;
    exp_t e;
    direction = dir;
    model_move(dir);
    sb.push_back(pack_model());
    screenClock = 1'b1;
    seen = 0;
    for (budget = 0; budget < 16 && !seen; budget++) begin
      @(negedge clock);
      if (moveDone === 1'b1) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $error("FAIL move_timeout observed=no_moveDone expected=moveDone");
      sb.delete(0);
    end else begin
      e = sb.pop_front();
      $display("move dir=%b head=(%0d,%0d) size=%0d", dir, snakeLocX[7:0], snakeLocY[8:0], size);
      check("move_latency", 64'(budget), 64'd4);
      check("size", size, e.sz);
      check_buses("move", e);
      @(negedge clock);
      check("moveDone_single", moveDone, 1'b0);
    end
    screenClock = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_head_x"}, snakeLocX[7:0], 8'd100);
    check({tag, "_head_y"}, snakeLocY[8:0], 9'd160);
    check({tag, "_seg1_y"}, snakeLocY[17:9], 9'd170);
    check({tag, "_seg2_y"}, snakeLocY[26:18], 9'd180);
    check({tag, "_size"}, size, 8'd3);
    check({tag, "_halted"}, halted, 1'b0);
    check({tag, "_moveDone"}, moveDone, 1'b0);
    model_reset();
    check_buses(tag, pack_model());
  endtask

  initial begin
    exp_t snap;
    int   md;
    logic [7:0] seg2x;
    logic [8:0] seg2y;

    reset = 1'b1;
    screenClock = 1'b0;
    direction = 2'b00;
    appleEaten = 1'b0;
    collision = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_reset_state("reset");
    repeat (3) @(negedge clock);

    // One move right
    do_move(2'b11);
    check("t2_head_x", snakeLocX[7:0], 8'd110);
    check("t2_seg1_x", snakeLocX[15:8], 8'd100);
    check("t2_seg2_y", snakeLocY[26:18], 9'd170);

    // Grow while turning up; new tail copies the old tail
    seg2x = snakeLocX[23:16];
    seg2y = snakeLocY[26:18];
    apple();
    do_move(2'b00);
    check("t3_size", size, 8'd4);
    check("t3_head_y", snakeLocY[8:0], 9'd150);
    check("t3_seg3_x", snakeLocX[31:24], seg2x);
    check("t3_seg3_y", snakeLocY[35:27], seg2y);

    // Reversal request while heading up
    do_move(2'b01);
`ifdef SNAKE_REVERSE_GUARD_EN
    check("t4_head_y", snakeLocY[8:0], 9'd140);
`else
    check("t4_head_y", snakeLocY[8:0], 9'd160);
`endif

    // Head x wraps below zero
    for (int i = 0; i < 12; i++) do_move(2'b10);
    check("t6_wrap_x", snakeLocX[7:0], 8'd246);

    // Two pulses before one tick merge into a single segment
    apple();
    apple();
    do_move(2'b00);
    check("merge_size", size, 8'd5);

    // Grow to the ceiling, then one more apple must not exceed it
    for (int i = 0; msize < 127 && i < 200; i++) begin
      apple();
      do_move(i[0] ? 2'b11 : 2'b00);
    end
    check("sat_size", size, 8'd127);
    apple();
    do_move(2'b00);
    check("sat_size_hold", size, 8'd127);

    // Collision coincident with a tick
    snap = pack_model();
    direction = 2'b11;
    screenClock = 1'b1;
    @(negedge clock);
    collision = 1'b1;
    md = 0;
    repeat (6) begin
      @(negedge clock);
      if (moveDone === 1'b1) md++;
    end
    check("halt_flag", halted, 1'b1);
    check("halt_no_move", 64'(md), 64'd0);
    check_buses("halt", snap);
    collision = 1'b0;
    for (int i = 0; i < 3; i++) begin
      screenClock = 1'b0;
      repeat (4) @(negedge clock);
      screenClock = 1'b1;
      appleEaten = (i == 0);
      repeat (4) begin
        @(negedge clock);
        appleEaten = 1'b0;
        if (moveDone === 1'b1) md++;
      end
    end
    screenClock = 1'b0;
    check("halt_sticky", halted, 1'b1);
    check("halt_ticks_ignored", 64'(md), 64'd0);
    check("halt_size", size, 8'd127);
    check_buses("halt_hold", snap);

    // Asynchronous reset between clock edges
    @(negedge clock);
    #3 reset = 1'b1;
    #1 check_reset_state("async_reset");
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    do_move(2'b11);
    check("post_reset_head_x", snakeLocX[7:0], 8'd110);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
